// File: rtl/imoy_pkg.sv
// Shared defaults and elaboration-time helpers for the IMOY weight generator.
package imoy_pkg;

    localparam int DEF_DW_IN       = 10;
    localparam int DEF_DW_DEC      = 8;
    localparam int DEF_CH          = 4;
    localparam int DEF_SEG_BITS    = 6;
    localparam int DEF_ALIGN_DELAY = 21;

    function automatic int LOG2(input int value);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) r = b + 1;
        end
        return r;
    endfunction

    // Knot k of the identity curve; the final knot lands exactly on 1.0.
    function automatic int ramp_knot(input int k, input int dw_dec, input int seg_bits);
        return (k << dw_dec) >> seg_bits;
    endfunction

endpackage

// File: rtl/pipe_dly.sv
// Fixed-latency register delay line with async active-low clear.
// A DEPTH of zero collapses to a plain wire.
module pipe_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused_clk;
            assign w_unused_clk = clk ^ rst_n;
            assign o_data       = i_data;
        end else begin : g_regs
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
                end else begin
                    r_pipe[0] <= i_data;
                    for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
                end
            end

            assign o_data = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/imoy_weight_gen.sv
// IMOY weight generator: per-pixel channel mean mapped through a piecewise-linear
// knot curve, with delay lines keeping pixel, mean and weight mutually aligned.
module imoy_weight_gen
    import imoy_pkg::*;
#(
    parameter int DW_IN       = DEF_DW_IN,
    parameter int DW_DEC      = DEF_DW_DEC,
    parameter int CH          = DEF_CH,
    parameter int SEG_BITS    = DEF_SEG_BITS,
    parameter int ALIGN_DELAY = DEF_ALIGN_DELAY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    input  logic [DW_IN*CH-1:0]    imcin,
    input  logic                   bypass,
    input  logic                   lut_we,
    input  logic [SEG_BITS:0]      lut_addr,
    input  logic [DW_DEC:0]        lut_wdata,
    input  logic                   lut_commit,
    output logic                   out_vld,
    output logic [DW_IN-1:0]       imoy_d,
    output logic [DW_DEC:0]        m_d,
    output logic [DW_IN*CH-1:0]    imcin_d
);

    localparam int LG  = LOG2(CH);
    localparam int SW  = DW_IN + LG;
    localparam int FB  = DW_IN - SEG_BITS;
    localparam int NK  = (1 << SEG_BITS) + 1;
    localparam int MW  = DW_DEC + 1;
    localparam int PW  = MW + FB + 2;
    localparam int IW  = SEG_BITS + 1;
    localparam int LAT = 4 + ALIGN_DELAY;

    localparam logic [MW-1:0] ONE_M = {1'b1, {DW_DEC{1'b0}}};
    localparam logic [PW-1:0] ONE_P = {{(PW-MW){1'b0}}, ONE_M};
    localparam logic [IW-1:0] KMAX  = {1'b1, {SEG_BITS{1'b0}}};

    logic [MW-1:0] r_shadow [NK];
    logic [MW-1:0] r_act    [NK];

    // Both statements are non-blocking, so a commit always copies the shadow
    // as it stood before a write landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) begin
                r_shadow[k] <= MW'(ramp_knot(k, DW_DEC, SEG_BITS));
                r_act[k]    <= MW'(ramp_knot(k, DW_DEC, SEG_BITS));
            end
        end else begin
            if (lut_we && (lut_addr <= KMAX)) r_shadow[lut_addr] <= lut_wdata;
            if (lut_commit) r_act <= r_shadow;
        end
    end

    logic [SW-1:0]    w_sum;
    logic [DW_IN-1:0] w_mean;
    logic [IW-1:0]    w_idx0;
    logic [IW-1:0]    w_idx1;

    logic [SW-1:0]    r_sum;
    logic [DW_IN-1:0] r_imoy;
    logic [MW-1:0]    r_y0;
    logic [MW-1:0]    r_y1;
    logic [FB-1:0]    r_frac;
    logic [MW-1:0]    r_m;

    always_comb begin
        w_sum = '0;
        for (int c = 0; c < CH; c++) begin
            w_sum = w_sum + SW'(imcin[c*DW_IN +: DW_IN]);
        end
    end

    assign w_mean = DW_IN'(r_sum >> LG);
    assign w_idx0 = {1'b0, r_imoy[DW_IN-1 -: SEG_BITS]};
    assign w_idx1 = w_idx0 + IW'(1);

    logic signed [MW:0]   w_diff;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_step;
    logic signed [PW-1:0] w_interp;
    logic        [MW-1:0] w_m;

    // Signed slope times unsigned fraction, floored by the arithmetic shift.
    always_comb begin
        w_diff   = $signed({1'b0, r_y1}) - $signed({1'b0, r_y0});
        w_prod   = $signed({{(PW-MW-1){w_diff[MW]}}, w_diff}) *
                   $signed({{(PW-FB){1'b0}}, r_frac});
        w_step   = w_prod >>> FB;
        w_interp = $signed({{(PW-MW){1'b0}}, r_y0}) + w_step;
        if (w_interp[PW-1]) begin
            w_m = '0;
        end else if ($unsigned(w_interp) > ONE_P) begin
            w_m = ONE_M;
        end else begin
            w_m = w_interp[MW-1:0];
        end
    end

    // in_vld only qualifies imcin: it never stalls anything, it rides alongside
    // the data and emerges as out_vld with the same latency as the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_imoy <= '0;
            r_y0   <= '0;
            r_y1   <= '0;
            r_frac <= '0;
            r_m    <= '0;
        end else begin
            r_sum  <= w_sum;
            r_imoy <= w_mean;
            r_y0   <= r_act[w_idx0];
            r_y1   <= r_act[w_idx1];
            r_frac <= r_imoy[FB-1:0];
            r_m    <= bypass ? ONE_M : w_m;
        end
    end

    pipe_dly #(.WIDTH(1), .DEPTH(LAT)) u_vld_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (in_vld),
        .o_data (out_vld)
    );

    pipe_dly #(.WIDTH(DW_IN*CH), .DEPTH(LAT)) u_pix_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (imcin),
        .o_data (imcin_d)
    );

    pipe_dly #(.WIDTH(DW_IN), .DEPTH(ALIGN_DELAY + 2)) u_mean_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_imoy),
        .o_data (imoy_d)
    );

    pipe_dly #(.WIDTH(MW), .DEPTH(ALIGN_DELAY)) u_m_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_m),
        .o_data (m_d)
    );

endmodule

// File: tb/tb_imoy_weight_gen.sv
// Directed and randomised checks of imoy_weight_gen against a cycle-indexed
// reference model of the channel mean, knot curve and output alignment.
module tb_imoy_weight_gen;

    localparam int DW_IN       = 10;
    localparam int DW_DEC      = 8;
    localparam int CH          = 4;
    localparam int SEG_BITS    = 6;
    localparam int ALIGN_DELAY = 21;

    localparam int LAT   = 4 + ALIGN_DELAY;
    localparam int PIXW  = DW_IN * CH;
    localparam int MW    = DW_DEC + 1;
    localparam int NKNOT = (1 << SEG_BITS) + 1;
    localparam int ONE   = 1 << DW_DEC;
    localparam int SEGW  = 1 << (DW_IN - SEG_BITS);
    localparam int HN    = 8192;
    localparam int EW    = 1 + PIXW + DW_IN + MW;

    logic              clk;
    logic              rst_n;
    logic              in_vld;
    logic [PIXW-1:0]   imcin;
    logic              bypass;
    logic              lut_we;
    logic [SEG_BITS:0] lut_addr;
    logic [DW_DEC:0]   lut_wdata;
    logic              lut_commit;
    logic              out_vld;
    logic [DW_IN-1:0]  imoy_d;
    logic [DW_DEC:0]   m_d;
    logic [PIXW-1:0]   imcin_d;

    imoy_weight_gen #(
        .DW_IN       (DW_IN),
        .DW_DEC      (DW_DEC),
        .CH          (CH),
        .SEG_BITS    (SEG_BITS),
        .ALIGN_DELAY (ALIGN_DELAY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .imcin      (imcin),
        .bypass     (bypass),
        .lut_we     (lut_we),
        .lut_addr   (lut_addr),
        .lut_wdata  (lut_wdata),
        .lut_commit (lut_commit),
        .out_vld    (out_vld),
        .imoy_d     (imoy_d),
        .m_d        (m_d),
        .imcin_d    (imcin_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_bad;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int              m_shadow [NKNOT];
    int              m_act    [NKNOT];
    logic            h_vld    [HN];
    logic [PIXW-1:0] h_pix    [HN];
    int              h_mean   [HN];
    int              h_w      [HN];
    logic [EW-1:0]   exp_q[$];
    int              cyc;

    logic             obs_vld;
    logic [PIXW-1:0]  obs_pix;
    logic [DW_IN-1:0] obs_mean;
    logic [DW_DEC:0]  obs_m;

    // Curve value at a given mean: linear between neighbouring knots, floored, clamped to [0, 1.0].
    function automatic int ref_weight(input int mean);
        int seg, pos, y0, y1, num, q, r;
        seg = mean / SEGW;
        pos = mean % SEGW;
        y0  = m_act[seg];
        y1  = m_act[seg + 1];
        num = (y1 - y0) * pos;
        if (num >= 0) q = num / SEGW;
        else          q = -((-num + SEGW - 1) / SEGW);
        r = y0 + q;
        if (r < 0)   r = 0;
        if (r > ONE) r = ONE;
        return r;
    endfunction

    function automatic logic [PIXW-1:0] all_ch(input int v);
        logic [DW_IN-1:0] c;
        c = DW_IN'(v);
        return {CH{c}};
    endfunction

    function automatic logic [PIXW-1:0] rand_pix();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PIXW-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NKNOT; k++) begin
            m_shadow[k] = k * ONE / (NKNOT - 1);
            m_act[k]    = m_shadow[k];
        end
        exp_q.delete();
        for (int k = 0; k < LAT - 3; k++) exp_q.push_back('0);
        cyc = 0;
    endtask

    // One clock: sample and score outputs mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        int            p;
        int            mean;
        int            mval;
        logic [EW-1:0] e;
        @(negedge clk);
        obs_vld  = out_vld;
        obs_pix  = imcin_d;
        obs_mean = imoy_d;
        obs_m    = m_d;
        mean = 0;
        for (int c = 0; c < CH; c++) mean += int'(imcin[c*DW_IN +: DW_IN]);
        mean = mean / CH;
        h_vld[cyc]  = in_vld;
        h_pix[cyc]  = imcin;
        h_mean[cyc] = mean;
        if (cyc >= 2) h_w[cyc-2] = ref_weight(h_mean[cyc-2]);
        p = cyc - 3;
        if (p >= 0) begin
            mval = bypass ? ONE : h_w[p];
            e = {h_vld[p], h_pix[p], DW_IN'(h_mean[p]), MW'(mval)};
        end else begin
            mval = bypass ? ONE : 0;
            e = {1'b0, {PIXW{1'b0}}, {DW_IN{1'b0}}, MW'(mval)};
        end
        exp_q.push_back(e);
        e = exp_q.pop_front();
        check_eq("out_vld", 64'(obs_vld),  64'(e[EW-1]));
        check_eq("imcin_d", 64'(obs_pix),  64'(e[EW-2 -: PIXW]));
        check_eq("imoy_d",  64'(obs_mean), 64'(e[MW +: DW_IN]));
        check_eq("m_d",     64'(obs_m),    64'(e[MW-1:0]));
        if (lut_commit) m_act = m_shadow;
        if (lut_we && int'(lut_addr) <= NKNOT - 1) m_shadow[int'(lut_addr)] = int'(lut_wdata);
        if (cyc < HN - 1) cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        in_vld = 1'b0;
        repeat (k) tick();
    endtask

    task automatic send_pix(input logic [PIXW-1:0] d);
        in_vld = 1'b1;
        imcin  = d;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic lut_write(input int addr, input int data);
        lut_we    = 1'b1;
        lut_addr  = (SEG_BITS+1)'(addr);
        lut_wdata = MW'(data);
        tick();
        lut_we    = 1'b0;
    endtask

    task automatic commit_pulse();
        lut_commit = 1'b1;
        tick();
        lut_commit = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_vld"}, 64'(out_vld), 64'(0));
        check_eq({tag, "_pix"}, 64'(imcin_d), 64'(0));
        check_eq({tag, "_imoy"}, 64'(imoy_d), 64'(0));
        check_eq({tag, "_m"}, 64'(m_d), 64'(0));
    endtask

    logic [PIXW-1:0] sp_pix [4];
    logic            sp_vld [4];
    int              first_vld;

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst_n      = 1'b1;
        in_vld     = 1'b0;
        imcin      = '0;
        bypass     = 1'b0;
        lut_we     = 1'b0;
        lut_addr   = '0;
        lut_wdata  = '0;
        lut_commit = 1'b0;

        #1 rst_n = 1'b0;
        #2 check_outputs_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        idle(3);

        // Reset ramp: mean 512 sits on knot 32 of the identity curve.
        send_pix(all_ch(512));
        idle(LAT);
        check_eq("ramp_vld", 64'(obs_vld), 64'(1));
        check_eq("ramp_imoy", 64'(obs_mean), 64'(512));
        check_eq("ramp_m", 64'(obs_m), 64'(128));

        lut_write(32, 100);
        lut_write(33, 200);
        commit_pulse();
        send_pix(all_ch(520));
        idle(LAT);
        check_eq("interp_imoy", 64'(obs_mean), 64'(520));
        check_eq("interp_m", 64'(obs_m), 64'(150));

        lut_write(64, 256);
        commit_pulse();
        send_pix(all_ch(1023));
        idle(LAT);
        check_eq("top_imoy", 64'(obs_mean), 64'(1023));
        check_eq("top_m", 64'(obs_m), 64'(255));
        bypass = 1'b1;
        send_pix(all_ch(1023));
        idle(LAT);
        check_eq("bypass_m", 64'(obs_m), 64'(256));
        bypass = 1'b0;

        // Write and commit in the same cycle: the commit sees the old knot 10.
        lut_we     = 1'b1;
        lut_addr   = 7'd10;
        lut_wdata  = 9'd200;
        lut_commit = 1'b1;
        tick();
        lut_we     = 1'b0;
        lut_commit = 1'b0;
        send_pix(all_ch(160));
        idle(LAT);
        check_eq("race_old_m", 64'(obs_m), 64'(40));
        commit_pulse();
        send_pix(all_ch(160));
        idle(LAT);
        check_eq("race_new_m", 64'(obs_m), 64'(200));

        sp_vld[0] = 1'b1;
        sp_vld[1] = 1'b0;
        sp_vld[2] = 1'b1;
        sp_vld[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sp_pix[i] = rand_pix();
            in_vld    = sp_vld[i];
            imcin     = sp_pix[i];
            tick();
        end
        idle(LAT - 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("sparse_vld", 64'(obs_vld), 64'(sp_vld[i]));
            check_eq("sparse_pix", 64'(obs_pix), 64'(sp_pix[i]));
        end

        repeat (1500) begin
            in_vld = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       imcin = all_ch(1023);
                1:       imcin = all_ch(0);
                2:       imcin = all_ch(int'($urandom_range(0, 1023)));
                default: imcin = rand_pix();
            endcase
            bypass     = ($urandom_range(0, 7) == 0);
            lut_we     = ($urandom_range(0, 3) == 0);
            lut_addr   = (SEG_BITS+1)'($urandom_range(0, 127));
            lut_wdata  = MW'($urandom_range(0, 511));
            lut_commit = ($urandom_range(0, 15) == 0);
            tick();
        end
        lut_we     = 1'b0;
        lut_commit = 1'b0;
        bypass     = 1'b0;

        in_vld = 1'b1;
        repeat (30) begin
            imcin = rand_pix();
            tick();
        end
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        first_vld = -1;
        for (int k = 0; k < 60; k++) begin
            in_vld = 1'b1;
            imcin  = rand_pix();
            tick();
            if (obs_vld && first_vld < 0) first_vld = k;
        end
        check_eq("midrst_first_vld", 64'(first_vld), 64'(LAT));

        idle(LAT + 5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
